// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl -- bit-serial WIDTH-bit adder sequencer.
//
// A single 1-bit FullAdderCell is reused once per cycle, LSB first. The
// carry between bit positions is kept in a flop, and the result bits are
// assembled MSB-ward in a shift register.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  operation request, accepted when start & ready
//   a, b   WIDTH-bit operands, captured on an accepted start
//   cin    initial carry, captured on an accepted start
//   sub    (SERIAL_ADDER_SUB_EN only) 1 = compute a - b
//   ready  high while idle
//   busy   high while bits are being processed
//   done   one-cycle pulse; sum/cout valid from here until the next start
//   sum    WIDTH-bit result
//   cout   final carry-out (under subtraction: 1 = no borrow)
//
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub input.
//
// Parameter WIDTH: operand/result width, legal range 1..64.

module FullAdderCell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic co
);
    assign sum = a ^ b ^ cin;
    assign co  = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // One extra counter bit so the terminal value WIDTH-1 never aliases a wrap.
    localparam int unsigned   CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             cell_sum;
    logic             cell_co;
    logic [WIDTH-1:0] sum_shift;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    FullAdderCell u_fa (
        .a   (op_a[0]),
        .b   (op_b[0]),
        .cin (carry),
        .sum (cell_sum),
        .co  (cell_co)
    );

    // Written as shift-then-insert so that WIDTH=1 needs no empty slice.
    always_comb begin
        sum_shift            = sum >> 1;
        sum_shift[WIDTH-1]   = cell_sum;
    end

    // Subtraction is a + ~b + 1: invert B and force the initial carry.
`ifdef SERIAL_ADDER_SUB_EN
    always_comb begin
        b_load = sub ? ~b : b;
        c_load = sub | cin;
    end
`else
    always_comb begin
        b_load = b;
        c_load = cin;
    end
`endif

    assign ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b_load;
                        carry <= c_load;
                        cnt   <= '0;
                        sum   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    sum   <= sum_shift;
                    carry <= cell_co;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        cout  <= cell_co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed testbench for serial_adder_ctrl at WIDTH=8.
// Define SERIAL_ADDER_SUB_EN on both files to also exercise subtraction.

module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub;
`endif
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int checks   = 0;
    int failures = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it; outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and follow it to completion. When inject_at is
    // nonzero, a competing start is pulsed at that RUN sample and must be ignored.
    task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic ic, input logic isub, input logic [7:0] es,
                          input logic ec, input int inject_at);
        int   cycles;
        int   busy_n;
        int   extra;
        logic held;
        a   = ia;
        b   = ib;
        cin = ic;
`ifdef SERIAL_ADDER_SUB_EN
        sub = isub;
`else
        if (isub) $display("note: sub requested without SERIAL_ADDER_SUB_EN");
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_ready_lo"}, {63'd0, ready}, 64'd0);
        cycles = 1;
        busy_n = 0;
        while (!done && cycles < 30) begin
            if (busy) busy_n++;
            if (cycles == inject_at) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'h55;
            end else begin
                start = 1'b0;
            end
            tick();
            cycles++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(cycles), 64'd9);
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'd8);
        check({tag, "_sum"}, {56'd0, sum}, {56'd0, es});
        check({tag, "_cout"}, {63'd0, cout}, {63'd0, ec});
        check({tag, "_done_state"}, {62'd0, busy, ready}, 64'd0);
        held  = 1'b1;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) extra++;
            if (sum !== es || cout !== ec || ready !== 1'b1) held = 1'b0;
        end
        check({tag, "_extra_done"}, 64'(extra), 64'd0);
        check({tag, "_held"}, {63'd0, held}, 64'd1);
    endtask

    initial begin
        int t_done[$];
        int cyc;
        logic any_done;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", {63'd0, ready}, 64'd1);
        check("rst_busy",  {63'd0, busy},  64'd0);
        check("rst_done",  {63'd0, done},  64'd0);
        check("rst_sum",   {56'd0, sum},   64'd0);
        check("rst_cout",  {63'd0, cout},  64'd0);

        run_op("add_03_05",   8'h03, 8'h05, 1'b0, 1'b0, 8'h08, 1'b0, 0);
        run_op("add_ff_01",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 0);
        run_op("add_00_cin",  8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 0);
        run_op("add_a5_5a_c", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 0);
        run_op("ign_start",   8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 3);

        // Abort an operation with reset at its fourth RUN sample.
        a     = 8'hFF;
        b     = 8'hFF;
        cin   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("abort_busy_pre", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", {63'd0, ready}, 64'd1);
        check("abort_busy",  {63'd0, busy},  64'd0);
        check("abort_sum",   {56'd0, sum},   64'd0);
        check("abort_cout",  {63'd0, cout},  64'd0);
        any_done = done;
        for (int i = 0; i < 10; i++) begin
            tick();
            any_done = any_done | done;
        end
        check("abort_no_done", {63'd0, any_done}, 64'd0);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 0);

        // rst and start together: reset wins, nothing starts.
        a     = 8'h11;
        b     = 8'h22;
        start = 1'b1;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_ready", {63'd0, ready}, 64'd1);
        check("rst_start_busy",  {63'd0, busy},  64'd0);

        // Start held high: one acceptance every IDLE+8*RUN+DONE = 10 cycles.
        a     = 8'h01;
        b     = 8'h02;
        cin   = 1'b0;
        start = 1'b1;
        cyc   = 0;
        while (t_done.size() < 3 && cyc < 60) begin
            tick();
            cyc++;
            if (done) begin
                t_done.push_back(cyc);
                check("b2b_sum", {56'd0, sum}, 64'h03);
            end
        end
        start = 1'b0;
        check("b2b_count", 64'(t_done.size()), 64'd3);
        if (t_done.size() == 3) begin
            check("b2b_first",   64'(t_done[0]), 64'd9);
            check("b2b_space_1", 64'(t_done[1] - t_done[0]), 64'd10);
            check("b2b_space_2", 64'(t_done[2] - t_done[1]), 64'd10);
        end
        tick();
        tick();

`ifdef SERIAL_ADDER_SUB_EN
        run_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 0);
        run_op("sub_07_05", 8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 0);
        run_op("sub0_add",  8'h07, 8'h05, 1'b0, 1'b0, 8'h0C, 1'b0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
